// File: rtl/line_engine.sv
// line_engine: Bresenham line rasteriser. It takes a line on a start/ready
// handshake and streams one pixel per cycle on a valid/ready port.
// Define LINE_ENGINE_CLIP_EN to retire off-screen pixels internally instead of
// emitting them.
module line_engine #(
    parameter int COORD_W  = 11,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic               start_ready,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_last,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    state_t                    state, state_nxt;
    logic [COORD_W-1:0]        lx0, ly0, lx1, ly1;
    logic [COORD_W-1:0]        maj, mnr, maj_end, dmaj, dmin;
    logic                      steep, step_neg;
    logic signed [COORD_W+1:0] err, err_sum;
    logic [COORD_W-1:0]        dx, dy, a0, b0, a1, b1;
    logic [COORD_W-1:0]        s_maj, s_maj_end, s_min, e_min;
    logic                      s_steep, s_swap;
    logic                      accept, visible, advance, last_step;

    if (SCREEN_W > (1 << COORD_W) || SCREEN_H > (1 << COORD_W)) begin : g_bad_screen
        $error("screen size exceeds coordinate range");
    end

    assign accept    = start && start_ready;
    assign pix_x     = steep ? mnr : maj;
    assign pix_y     = steep ? maj : mnr;
    assign last_step = maj == maj_end;
    assign err_sum   = err + $signed({2'b00, dmin});

`ifdef LINE_ENGINE_CLIP_EN
    localparam logic [COORD_W:0] SCR_W = (COORD_W+1)'(SCREEN_W);
    localparam logic [COORD_W:0] SCR_H = (COORD_W+1)'(SCREEN_H);
    assign visible = ({1'b0, pix_x} < SCR_W) && ({1'b0, pix_y} < SCR_H);
`else
    assign visible = 1'b1;
`endif

    // Off-screen pixels retire without a handshake; visible ones wait for the consumer.
    assign pix_valid = (state == DRAW) && visible;
    assign pix_last  = pix_valid && last_step;
    assign advance   = (state == DRAW) && (pix_ready || !visible);

    // Setup geometry: pick the major axis and order the endpoints so major ascends.
    always_comb begin
        dx        = (lx1 >= lx0) ? lx1 - lx0 : lx0 - lx1;
        dy        = (ly1 >= ly0) ? ly1 - ly0 : ly0 - ly1;
        s_steep   = dy > dx;
        a0        = s_steep ? ly0 : lx0;
        b0        = s_steep ? lx0 : ly0;
        a1        = s_steep ? ly1 : lx1;
        b1        = s_steep ? lx1 : ly1;
        s_swap    = a1 < a0;
        s_maj     = s_swap ? a1 : a0;
        s_maj_end = s_swap ? a0 : a1;
        s_min     = s_swap ? b1 : b0;
        e_min     = s_swap ? b0 : b1;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            IDLE: begin
                start_ready = reset_n;
                busy        = 1'b0;
                state_nxt   = accept ? SETUP : IDLE;
            end
            SETUP: state_nxt = DRAW;
            DRAW:  state_nxt = (advance && last_step) ? DONE : DRAW;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Endpoint capture, setup load and one Bresenham step per retired pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lx0      <= '0;
            ly0      <= '0;
            lx1      <= '0;
            ly1      <= '0;
            maj      <= '0;
            mnr      <= '0;
            maj_end  <= '0;
            dmaj     <= '0;
            dmin     <= '0;
            steep    <= 1'b0;
            step_neg <= 1'b0;
            err      <= '0;
        end else begin
            if (accept) begin
                lx0 <= x0;
                ly0 <= y0;
                lx1 <= x1;
                ly1 <= y1;
            end
            if (state == SETUP) begin
                steep    <= s_steep;
                maj      <= s_maj;
                mnr      <= s_min;
                maj_end  <= s_maj_end;
                dmaj     <= s_maj_end - s_maj;
                dmin     <= (e_min >= s_min) ? e_min - s_min : s_min - e_min;
                step_neg <= e_min < s_min;
                err      <= -$signed({2'b00, (s_maj_end - s_maj) >> 1});
            end else if (advance && !last_step) begin
                maj <= maj + 1'b1;
                if (!err_sum[COORD_W+1]) begin
                    mnr <= step_neg ? mnr - 1'b1 : mnr + 1'b1;
                    err <= err_sum - $signed({2'b00, dmaj});
                end else begin
                    err <= err_sum;
                end
            end
        end
    end

endmodule
